// File: rtl/binary_ascii_tx_if.sv
// Handshake bundle for binary_ascii_tx: binary word in, ASCII character stream out.
// The slave modport is the formatter; the master modport is the producer/sink side.
interface binary_ascii_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_char;
    logic             word_done;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_char,
        output word_done
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_char,
        input  word_done
    );
endinterface

// File: rtl/binary_ascii_tx.sv
// Formats a WIDTH-bit word as MSB-first ASCII '0'/'1' characters, optionally
// terminated by a newline, over valid/ready handshakes on both sides.
module binary_ascii_tx #(
    parameter int WIDTH   = 8,
    parameter bit NEWLINE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    binary_ascii_tx_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        NL   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic             out_valid_q;
    logic [7:0]       out_char_q;

    logic [WIDTH-1:0] sh_shl;
    logic             last_bit;
    logic             bit_xfer;
    logic             nl_xfer;

    assign sh_shl   = sh_q << 1;
    assign last_bit = (cnt_q == CW'(1));
    assign bit_xfer = (state_q == BITS) && bus.out_ready;
    assign nl_xfer  = (state_q == NL) && bus.out_ready;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    // Reset suppresses the pulse even if a final transfer coincides with it.
    assign bus.word_done = !reset &&
                           ((bit_xfer && last_bit && !NEWLINE) || (nl_xfer && NEWLINE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh_q        <= bus.in_data;
                        cnt_q       <= CW'(WIDTH);
                        out_valid_q <= 1'b1;
                        out_char_q  <= 8'h30 | {7'b0, bus.in_data[WIDTH-1]};
                        state_q     <= BITS;
                    end
                end
                BITS: begin
                    if (bus.out_ready) begin
                        sh_q  <= sh_shl;
                        cnt_q <= cnt_q - CW'(1);
                        if (!last_bit) begin
                            // Preload the next bit so out_char stays a plain register.
                            out_char_q <= 8'h30 | {7'b0, sh_shl[WIDTH-1]};
                        end else if (NEWLINE) begin
                            out_char_q <= 8'h0A;
                            state_q    <= NL;
                        end else begin
                            out_valid_q <= 1'b0;
                            out_char_q  <= 8'h00;
                            state_q     <= IDLE;
                        end
                    end
                end
                NL: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_char_q  <= 8'h00;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    out_char_q  <= 8'h00;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_binary_ascii_tx.sv
// Self-checking bench for binary_ascii_tx: a WIDTH=8/NEWLINE=1 instance for the
// main scenarios and a WIDTH=1/NEWLINE=0 instance for the corner parameters.
module tb_binary_ascii_tx;
    logic clk;
    logic reset;
    int   cyc;
    int   tests_run;
    int   failed;

    binary_ascii_tx_if #(.WIDTH(8)) m ();
    binary_ascii_tx_if #(.WIDTH(1)) s ();

    binary_ascii_tx #(.WIDTH(8), .NEWLINE(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m.slave)
    );

    binary_ascii_tx #(.WIDTH(1), .NEWLINE(1'b0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs change just after posedge, so negedge sees what the next edge will see.
    logic [7:0] mon_chars[$];
    int         mon_cyc[$];
    bit         mon_wd[$];
    logic [7:0] acc_data[$];
    int         acc_cyc[$];
    int         wd_stray;
    int         stall_err;
    bit         prev_stall;
    logic [7:0] prev_char;

    always @(negedge clk) begin
        if (!reset && m.out_valid && m.out_ready) begin
            mon_chars.push_back(m.out_char);
            mon_cyc.push_back(cyc);
            mon_wd.push_back(m.word_done);
        end else if (m.word_done) begin
            wd_stray <= wd_stray + 1;
        end
        if (!reset && m.in_valid && m.in_ready) begin
            acc_data.push_back(m.in_data);
            acc_cyc.push_back(cyc);
        end
        if (prev_stall && (!m.out_valid || m.out_char !== prev_char))
            stall_err <= stall_err + 1;
        prev_stall <= !reset && m.out_valid && !m.out_ready;
        prev_char  <= m.out_char;
    end

    // Reference model: one ASCII digit per bit MSB first, then a newline.
    logic [7:0] exp_q[$];

    task automatic add_expected(input logic [7:0] d);
        for (int i = 7; i >= 0; i--)
            exp_q.push_back(((d >> i) & 8'd1) != 0 ? 8'h31 : 8'h30);
        exp_q.push_back(8'h0A);
    endtask

    task automatic clear_all();
        mon_chars.delete();
        mon_cyc.delete();
        mon_wd.delete();
        acc_data.delete();
        acc_cyc.delete();
        exp_q.delete();
        wd_stray  = 0;
        stall_err = 0;
    endtask

    // Offers one word when the block is idle and runs it to completion.
    // mode 0: out_ready high, 1: low every other cycle starting low, 2: random.
    task automatic run_word(input logic [7:0] d, input int mode, output int busy);
        bit alt;
        int n;
        alt  = 1'b0;
        busy = 0;
        n    = 0;
        m.in_valid  = 1'b1;
        m.in_data   = d;
        m.out_ready = 1'b1;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        while (!m.in_ready && n < 100) begin
            busy++;
            case (mode)
                0:       m.out_ready = 1'b1;
                1: begin m.out_ready = alt; alt = !alt; end
                default: m.out_ready = ($urandom_range(0, 1) == 1);
            endcase
            @(posedge clk); #1;
            n++;
        end
        m.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m.in_valid = 1'b0; m.in_data = 8'h00; m.out_ready = 1'b0;
        s.in_valid = 1'b0; s.in_data = 1'b0;  s.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if (m.in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready got %b want 1", m.in_ready); end
        tests_run++;
        if (m.out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b want 0", m.out_valid); end
        tests_run++;
        if (m.out_char !== 8'h00) begin failed++; $display("FAIL reset_out_char got %h want 00", m.out_char); end
        m.out_ready = 1'b1;
        #1;
        tests_run++;
        if (m.word_done !== 1'b0) begin failed++; $display("FAIL reset_word_done got %b want 0", m.word_done); end
        tests_run++;
        if (s.in_ready !== 1'b1 || s.out_valid !== 1'b0) begin
            failed++; $display("FAIL reset_w1 got in_ready=%b out_valid=%b want 1/0", s.in_ready, s.out_valid);
        end
        @(posedge clk); #1;
        $display("[TB] reset: idle outputs checked");
    endtask

    task automatic test_basic();
        int busy;
        clear_all();
        add_expected(8'hA5);
        run_word(8'hA5, 0, busy);
        repeat (2) @(posedge clk); #1;
        tests_run++;
        if (mon_chars.size() != 9) begin failed++; $display("FAIL basic_len got %0d want 9", mon_chars.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= mon_chars.size() || mon_chars[i] !== exp_q[i] || mon_wd[i] !== (i == 8)) begin
                failed++;
                $display("FAIL basic_char%0d got %h wd=%b want %h wd=%b", i,
                         (i < mon_chars.size()) ? mon_chars[i] : 8'hxx,
                         (i < mon_wd.size()) ? mon_wd[i] : 1'bx, exp_q[i], (i == 8));
            end
        end
        tests_run++;
        if (acc_cyc.size() != 1 || mon_cyc.size() != 9 || mon_cyc[0] != acc_cyc[0] + 1 || mon_cyc[8] != acc_cyc[0] + 9) begin
            failed++; $display("FAIL basic_timing got first/last char not at accept+1..accept+9");
        end
        tests_run++;
        if (busy != 9) begin failed++; $display("FAIL basic_busy got %0d want 9", busy); end
        tests_run++;
        if (wd_stray != 0) begin failed++; $display("FAIL basic_wd_stray got %0d want 0", wd_stray); end
        $display("[TB] basic: word A5 -> %0d chars, busy %0d", mon_chars.size(), busy);
    endtask

    task automatic test_extremes();
        int busy;
        logic [7:0] words[2];
        words[0] = 8'h00;
        words[1] = 8'hFF;
        foreach (words[w]) begin
            clear_all();
            add_expected(words[w]);
            run_word(words[w], 0, busy);
            @(posedge clk); #1;
            tests_run++;
            if (mon_chars.size() != 9) begin failed++; $display("FAIL extreme_len got %0d want 9", mon_chars.size()); end
            foreach (exp_q[i]) begin
                tests_run++;
                if (i >= mon_chars.size() || mon_chars[i] !== exp_q[i]) begin
                    failed++; $display("FAIL extreme_char%0d got %h want %h", i,
                                       (i < mon_chars.size()) ? mon_chars[i] : 8'hxx, exp_q[i]);
                end
            end
            tests_run++;
            if (busy != 9) begin failed++; $display("FAIL extreme_busy got %0d want 9", busy); end
            $display("[TB] extremes: word %h busy %0d", words[w], busy);
        end
    endtask

    task automatic test_backpressure();
        int busy;
        clear_all();
        add_expected(8'h3C);
        run_word(8'h3C, 1, busy);
        @(posedge clk); #1;
        tests_run++;
        if (mon_chars.size() != 9) begin failed++; $display("FAIL bp_len got %0d want 9", mon_chars.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= mon_chars.size() || mon_chars[i] !== exp_q[i]) begin
                failed++; $display("FAIL bp_char%0d got %h want %h", i,
                                   (i < mon_chars.size()) ? mon_chars[i] : 8'hxx, exp_q[i]);
            end
        end
        tests_run++;
        if (busy != 18) begin failed++; $display("FAIL bp_busy got %0d want 18", busy); end
        tests_run++;
        if (stall_err != 0) begin failed++; $display("FAIL bp_hold got %0d changes want 0", stall_err); end
        $display("[TB] backpressure: word 3C busy %0d", busy);
    endtask

    task automatic test_busy_ignore();
        int n;
        clear_all();
        add_expected(8'h0F);
        add_expected(8'hF0);
        m.out_ready = 1'b1;
        m.in_valid  = 1'b1;
        m.in_data   = 8'h0F;
        @(posedge clk); #1;
        m.in_data = 8'hF0;
        n = 0;
        while (acc_data.size() < 2 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        m.in_valid = 1'b0;
        n = 0;
        while (!m.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        tests_run++;
        if (acc_data.size() != 2 || acc_data[0] !== 8'h0F || acc_data[1] !== 8'hF0 || acc_cyc[1] - acc_cyc[0] != 10) begin
            failed++; $display("FAIL busy_accept got %0d accepts want 0F then F0 ten cycles apart", acc_data.size());
        end
        tests_run++;
        if (mon_chars.size() != 18) begin failed++; $display("FAIL busy_len got %0d want 18", mon_chars.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= mon_chars.size() || mon_chars[i] !== exp_q[i]) begin
                failed++; $display("FAIL busy_char%0d got %h want %h", i,
                                   (i < mon_chars.size()) ? mon_chars[i] : 8'hxx, exp_q[i]);
            end
        end
        tests_run++;
        if (mon_cyc.size() != 18 || mon_cyc[9] - mon_cyc[8] != 2) begin
            failed++; $display("FAIL busy_gap got size %0d want one idle cycle between words", mon_cyc.size());
        end
        $display("[TB] busy_ignore: %0d accepts, %0d chars", acc_data.size(), mon_chars.size());
    endtask

    task automatic test_reset_midword();
        int busy;
        clear_all();
        m.out_ready = 1'b1;
        m.in_valid  = 1'b1;
        m.in_data   = 8'h96;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (m.word_done !== 1'b0) begin failed++; $display("FAIL rst_wd_prio got %b want 0", m.word_done); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (m.out_valid !== 1'b0 || m.out_char !== 8'h00 || m.in_ready !== 1'b1) begin
            failed++; $display("FAIL rst_mid_state got valid=%b char=%h ready=%b want 0/00/1",
                               m.out_valid, m.out_char, m.in_ready);
        end
        repeat (3) @(posedge clk); #1;
        tests_run++;
        if (mon_chars.size() != 3 || mon_chars[0] !== 8'h31 || mon_chars[1] !== 8'h30 || mon_chars[2] !== 8'h30) begin
            failed++; $display("FAIL rst_mid_chars got %0d chars want 31 30 30", mon_chars.size());
        end
        tests_run++;
        if (wd_stray != 0 || (mon_wd.size() > 0 && (mon_wd[0] | mon_wd[mon_wd.size()-1]))) begin
            failed++; $display("FAIL rst_mid_wd got stray=%0d want no word_done", wd_stray);
        end
        clear_all();
        add_expected(8'h01);
        run_word(8'h01, 0, busy);
        @(posedge clk); #1;
        tests_run++;
        if (mon_chars.size() != 9) begin failed++; $display("FAIL rst_next_len got %0d want 9", mon_chars.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= mon_chars.size() || mon_chars[i] !== exp_q[i]) begin
                failed++; $display("FAIL rst_next_char%0d got %h want %h", i,
                                   (i < mon_chars.size()) ? mon_chars[i] : 8'hxx, exp_q[i]);
            end
        end
        $display("[TB] reset_midword: aborted 96, then 01 -> %0d chars", mon_chars.size());
    endtask

    task automatic test_random();
        int busy;
        int total_busy;
        logic [7:0] d;
        clear_all();
        total_busy = 0;
        for (int w = 0; w < 20; w++) begin
            d = 8'($urandom);
            add_expected(d);
            run_word(d, 2, busy);
            total_busy += busy;
            $display("[TB] random: word %h busy %0d", d, busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (mon_chars.size() != exp_q.size()) begin
            failed++; $display("FAIL rand_len got %0d want %0d", mon_chars.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= mon_chars.size() || mon_chars[i] !== exp_q[i] || mon_wd[i] !== ((i % 9) == 8)) begin
                failed++; $display("FAIL rand_char%0d got %h want %h", i,
                                   (i < mon_chars.size()) ? mon_chars[i] : 8'hxx, exp_q[i]);
            end
        end
        tests_run++;
        if (stall_err != 0 || wd_stray != 0) begin
            failed++; $display("FAIL rand_hold got stall=%0d stray=%0d want 0/0", stall_err, wd_stray);
        end
        tests_run++;
        if (total_busy < 180) begin failed++; $display("FAIL rand_busy got %0d want at least 180", total_busy); end
    endtask

    task automatic test_corner_w1();
        logic [7:0] want;
        logic       d;
        for (int k = 0; k < 2; k++) begin
            d    = (k == 0);
            want = 8'h30 + {7'b0, d};
            s.out_ready = 1'b1;
            s.in_valid  = 1'b1;
            s.in_data   = d;
            @(posedge clk); #1;
            s.in_valid = 1'b0;
            #1;
            tests_run++;
            if (s.in_ready !== 1'b0 || s.out_valid !== 1'b1 || s.out_char !== want || s.word_done !== 1'b1) begin
                failed++; $display("FAIL w1_char got ready=%b valid=%b char=%h wd=%b want 0/1/%h/1",
                                   s.in_ready, s.out_valid, s.out_char, s.word_done, want);
            end
            @(posedge clk); #1;
            tests_run++;
            if (s.in_ready !== 1'b1 || s.out_valid !== 1'b0 || s.word_done !== 1'b0) begin
                failed++; $display("FAIL w1_idle got ready=%b valid=%b wd=%b want 1/0/0",
                                   s.in_ready, s.out_valid, s.word_done);
            end
            $display("[TB] corner_w1: bit %b -> char %h", d, s.out_char);
        end
    endtask

    initial begin
        cyc = 0; tests_run = 0; failed = 0;
        wd_stray = 0; stall_err = 0; prev_stall = 1'b0; prev_char = 8'h00;
        reset = 1'b1;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_busy_ignore();
        test_reset_midword();
        test_random();
        test_corner_w1();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/binary_ascii_tx.md
# binary_ascii_tx

Transmit-side formatter for the console bit-entry protocol. The protocol is one ASCII character per bit, '0' = 0x30 and '1' = 0x31, and each entry is terminated by a newline (0x0A). This block accepts a WIDTH-bit binary word over a valid/ready handshake and emits it MSB-first as an ASCII byte stream over a second valid/ready handshake, optionally followed by a newline. It sits between any binary-producing datapath and the character sink: a UART transmitter, or a bench console writer.

## Interface
- WIDTH, 8: bits per word; legal range 1..32.
- NEWLINE, 1: 1 appends 0x0A after the last bit character; 0 omits it.

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  in_data is offered.
- in_ready  output  1  block can accept a word; equals (state == IDLE).
- in_data  input  WIDTH  word to transmit; bit WIDTH-1 goes out first.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  sink accepts out_char this cycle.
- out_char  output  8  ASCII byte: 0x30, 0x31 or 0x0A.
- word_done  output  1  one-cycle pulse on the cycle the final character of a word is accepted.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0. Exits on in_valid && in_ready: capture in_data into shift register sh, set cnt=WIDTH, go to BITS.
  - BITS: out_valid=1, out_char = 0x30 + sh[WIDTH-1]. On out_ready: shift sh left by 1 and decrement cnt. When the accepted char is the last one (cnt==1), go to NL if NEWLINE=1, otherwise go to IDLE.
  - NL: out_valid=1, out_char=0x0A. On out_ready, go to IDLE.
- Handshake rules:
  - A transfer occurs only on a cycle where valid && ready.
  - out_char and out_valid are registered. They hold stable while out_valid && !out_ready.
  - in_valid is ignored outside IDLE. No data is captured and in_ready stays 0.
- Arithmetic and widths:
  - cnt width is clog2(WIDTH+1).
  - out_char is formed as 8'h30 | {7'b0, bit}. No other values are ever produced.
- word_done is asserted combinationally from state and out_ready: last BITS char accepted with NEWLINE=0, or NL accepted with NEWLINE=1.
- Reset:
  - Returns to IDLE from any state on the next edge and discards any partial word. No newline is emitted for the aborted word.
  - Reset values: state=IDLE, sh=0, cnt=0, out_valid=0, out_char=0x00, word_done=0, in_ready=1 from the first cycle after reset.
  - Reset has priority over every handshake in the same cycle.

## Timing
- Word accepted at edge k. First character is valid in cycle k+1, i.e. 1-cycle latency.
- With out_ready held high:
  - characters transfer on consecutive cycles;
  - one word occupies 1 + WIDTH + NEWLINE cycles, IDLE included;
  - in_ready returns high the cycle after the last character transfer.
- Back-to-back words are not overlapped. There is exactly one IDLE cycle between words when in_valid is held high.
- Backpressure: each stalled cycle extends the word by exactly one cycle. No character is dropped or duplicated.
- Simultaneous events:
  - A char transfer and in_valid in the same cycle: in_valid is ignored, because in_ready=0.
  - reset with out_valid && out_ready in the same cycle: reset wins and word_done stays 0.

## Test plan
- Basic word: WIDTH=8, NEWLINE=1, in_data=0xA5, out_ready=1. Required bytes 0x31,0x30,0x31,0x30,0x30,0x31,0x30,0x31,0x0A on 9 consecutive cycles starting one cycle after acceptance. word_done pulses once, on the 0x0A transfer.
- Extremes: in_data=0x00 gives eight 0x30 then 0x0A; in_data=0xFF gives eight 0x31 then 0x0A. in_ready is low for exactly 9 cycles per word.
- Backpressure: 0x3C with out_ready low on every other cycle. Required bytes are the same 9, in order. out_char is held constant through each stall and the word takes 18 cycles.
- Busy-input ignore: present 0x0F in_valid, then hold in_valid with in_data=0xF0 throughout the transmission. Required output is 0x0F's characters. 0xF0 is accepted only on the next IDLE cycle and follows after exactly one gap cycle.
- Reset mid-word: assert reset after the 3rd character of 0x96. Required: out_valid=0, out_char=0x00, in_ready=1 the cycle after reset deasserts, and no 0x0A or word_done for the aborted word. The next word 0x01 emits cleanly.
- Corner parameters: WIDTH=1, NEWLINE=0, inputs 1 then 0. Required: single bytes 0x31 then 0x30, each with word_done on its transfer cycle. Each word takes 2 cycles.
